// File: rtl/spi_apb_arb.sv
// Round-robin arbiter that funnels several valid/ready requesters onto one APB
// master port, running one complete SETUP/ACCESS transfer per grant.
module spi_apb_arb #(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 16,
    parameter int APB_DATA_WIDTH = 32,
    localparam int IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [APB_DATA_WIDTH-1:0]          rsp_rdata,
    output logic [IW-1:0]                      gnt_idx,
    output logic                               busy,
    output logic                               apb_psel,
    output logic                               apb_penable,
    output logic                               apb_pwrite,
    output logic [APB_ADDR_WIDTH-1:0]          apb_paddr,
    output logic [APB_DATA_WIDTH-1:0]          apb_pwdata,
    input  logic                               apb_pready,
    input  logic [APB_DATA_WIDTH-1:0]          apb_prdata
);
    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t              state_reg, state_next;
    logic [IW-1:0]       last_reg, last_next;
    logic [IW-1:0]       gnt_reg, gnt_next;
    logic [NUM_REQ-1:0]  ready_reg, ready_next;
    logic [NUM_REQ-1:0]  rsp_reg, rsp_next;
    logic [DW-1:0]       rdata_reg, rdata_next;
    logic                busy_reg, busy_next;
    logic                psel_reg, psel_next;
    logic                penable_reg, penable_next;
    logic                pwrite_reg, pwrite_next;
    logic [AW-1:0]       paddr_reg, paddr_next;
    logic [DW-1:0]       pwdata_reg, pwdata_next;

    logic                win_found;
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       cand_idx;
    int                  cand;

    // Scan last+1, last+2, ... with wrap; the first set bit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_reg;
        cand      = 0;
        cand_idx  = '0;
        for (int o = 1; o <= NUM_REQ; o++) begin
            cand     = (int'(last_reg) + o) % NUM_REQ;
            cand_idx = IW'(cand);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        last_next    = last_reg;
        gnt_next     = gnt_reg;
        ready_next   = '0;
        rsp_next     = '0;
        rdata_next   = rdata_reg;
        busy_next    = busy_reg;
        psel_next    = psel_reg;
        penable_next = penable_reg;
        pwrite_next  = pwrite_reg;
        paddr_next   = paddr_reg;
        pwdata_next  = pwdata_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    pwrite_next          = req_write[win_idx];
                    paddr_next           = req_addr[win_idx*AW +: AW];
                    pwdata_next          = req_wdata[win_idx*DW +: DW];
                    ready_next[win_idx]  = 1'b1;
                    gnt_next             = win_idx;
                    last_next            = win_idx;
                    psel_next            = 1'b1;
                    penable_next         = 1'b0;
                    busy_next            = 1'b1;
                    state_next           = SETUP;
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
            end
            ACCESS: begin
                if (apb_pready) begin
                    if (!pwrite_reg) begin
                        rdata_next = apb_prdata;
                    end
                    psel_next         = 1'b0;
                    penable_next      = 1'b0;
                    rsp_next[gnt_reg] = 1'b1;
                    state_next        = DONE;
                end
            end
            DONE: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_reg    <= IW'(NUM_REQ - 1);
            gnt_reg     <= '0;
            ready_reg   <= '0;
            rsp_reg     <= '0;
            rdata_reg   <= '0;
            busy_reg    <= 1'b0;
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            pwrite_reg  <= 1'b0;
            paddr_reg   <= '0;
            pwdata_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            last_reg    <= last_next;
            gnt_reg     <= gnt_next;
            ready_reg   <= ready_next;
            rsp_reg     <= rsp_next;
            rdata_reg   <= rdata_next;
            busy_reg    <= busy_next;
            psel_reg    <= psel_next;
            penable_reg <= penable_next;
            pwrite_reg  <= pwrite_next;
            paddr_reg   <= paddr_next;
            pwdata_reg  <= pwdata_next;
        end
    end

    assign req_ready   = ready_reg;
    assign rsp_valid   = rsp_reg;
    assign rsp_rdata   = rdata_reg;
    assign gnt_idx     = gnt_reg;
    assign busy        = busy_reg;
    assign apb_psel    = psel_reg;
    assign apb_penable = penable_reg;
    assign apb_pwrite  = pwrite_reg;
    assign apb_paddr   = paddr_reg;
    assign apb_pwdata  = pwdata_reg;

endmodule

// File: tb/tb_spi_apb_arb.sv
// Directed bench for spi_apb_arb: cycle-accurate checks of grant order, APB
// phasing, response pulses, read-data holding and asynchronous reset.
module tb_spi_apb_arb;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [IW-1:0]   gnt_idx;
    logic            busy, apb_psel, apb_penable, apb_pwrite;
    logic [AW-1:0]   apb_paddr;
    logic [DW-1:0]   apb_pwdata;
    logic            apb_pready;
    logic [DW-1:0]   apb_prdata;

    always #5 clk = ~clk;

    spi_apb_arb #(.NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .gnt_idx(gnt_idx), .busy(busy),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata),
        .apb_pready(apb_pready), .apb_prdata(apb_prdata)
    );

    int            n_chk = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] addr_tab [N];
    logic [DW-1:0] wd_tab   [N];
    logic [DW-1:0] rd_tab   [N];
    logic          wr_tab   [N];
    int            order4   [6];
    int            order13  [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {req_ready, rsp_valid, rsp_rdata, gnt_idx, busy,
                              apb_psel, apb_penable, apb_pwrite}, 64'h0);
        check({tag, "_bus"}, {apb_paddr, apb_pwdata}, 64'h0);
    endtask

    task automatic load(input int i);
        req_write[i]           = wr_tab[i];
        req_addr[i*AW +: AW]   = addr_tab[i];
        req_wdata[i*DW +: DW]  = wd_tab[i];
    endtask

    // Expects requester 'who' to be granted at the next clock edge; follows
    // SETUP, ACCESS (waits+1 cycles), DONE and the following IDLE cycle.
    task automatic xfer(input int who, input int waits, input bit drop);
        logic [N-1:0] oh;
        oh = '0;
        oh[who] = 1'b1;
        @(negedge clk);
        check("setup_ready", req_ready, oh);
        check("setup_gnt", gnt_idx, who);
        check("setup_ctl", {apb_psel, apb_penable, busy}, 3'b101);
        check("setup_bus", {apb_pwrite, apb_paddr, apb_pwdata},
              {wr_tab[who], addr_tab[who], wd_tab[who]});
        if (drop) req_valid[who] = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            check("access_ctl", {apb_psel, apb_penable, busy}, 3'b111);
            check("access_ready", req_ready, 0);
            check("access_hold", {apb_pwrite, apb_paddr, apb_pwdata},
                  {wr_tab[who], addr_tab[who], wd_tab[who]});
            if (i == waits) begin
                apb_pready = 1'b1;
                apb_prdata = rd_tab[who];
            end else begin
                apb_prdata = ~rd_tab[who];
            end
        end
        if (!wr_tab[who]) exp_rd = rd_tab[who];
        @(negedge clk);
        apb_pready = 1'b0;
        apb_prdata = 32'h0;
        check("done_rsp", rsp_valid, oh);
        check("done_ctl", {apb_psel, apb_penable, busy}, 3'b001);
        check("done_rdata", rsp_rdata, exp_rd);
        @(negedge clk);
        check("idle_rsp", rsp_valid, 0);
        check("idle_ctl", {apb_psel, apb_penable, busy}, 3'b000);
        check("idle_rdata", rsp_rdata, exp_rd);
        $display("xfer req=%0d write=%0d addr=%h waits=%0d rdata=%h",
                 who, wr_tab[who], addr_tab[who], waits, rsp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        apb_pready = 1'b0;
        apb_prdata = '0;
        exp_rd     = '0;
        addr_tab = '{16'h0040, 16'h0111, 16'h1234, 16'h0333};
        wd_tab   = '{32'h0000_0000, 32'h1111_0001, 32'hDEAD_BEEF, 32'h3333_0003};
        wr_tab   = '{1'b0, 1'b1, 1'b1, 1'b1};
        rd_tab   = '{32'hA5A5_5A5A, 32'h0EEE_0001, 32'h0EEE_0002, 32'h0EEE_0003};
        order4   = '{0, 1, 2, 3, 0, 1};
        order13  = '{3, 1, 3, 1};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle_no_req");

        // Single read by requester 0, immediate pready.
        load(0);
        req_valid[0] = 1'b1;
        xfer(0, 0, 1'b1);

        // Single write by requester 2, pready in the third ACCESS cycle.
        load(2);
        req_valid[2] = 1'b1;
        xfer(2, 2, 1'b1);

        // Requester 3 alone, so the pointer sits at 3.
        load(3);
        req_valid[3] = 1'b1;
        xfer(3, 0, 1'b1);

        // All four continuously: order 0,1,2,3,0,1.
        rd_tab[0] = 32'h0F0F_1234;
        for (int i = 0; i < N; i++) load(i);
        req_valid = '1;
        foreach (order4[k]) xfer(order4[k], 0, 1'b0);
        req_valid = '0;

        // Requesters 1 and 3 with pointer at 1.
        req_valid = 4'b1010;
        foreach (order13[k]) xfer(order13[k], 0, 1'b0);
        req_valid = '0;

        // Long wait on pready.
        req_valid[2] = 1'b1;
        xfer(2, 600, 1'b1);

        // Reset in the middle of ACCESS of requester 1.
        req_valid[1] = 1'b1;
        @(negedge clk);
        check("rst_setup_ready", req_ready, 4'b0010);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("rst_access_ctl", {apb_psel, apb_penable}, 2'b11);
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        exp_rd = '0;
        req_valid = '1;
        apb_pready = 1'b1;
        @(negedge clk);
        check_zero("rst_held");
        apb_pready = 1'b0;
        rst_n = 1'b1;
        xfer(0, 0, 1'b1);
        req_valid = '0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_apb_arb.md
# spi_apb_arb

Round-robin arbiter and APB master sequencer that shares the single APB-to-SPI bridge between several on-chip requesters. Each requester presents a simple valid/ready command (read or write, address, write data). The block grants one requester at a time, runs one complete APB transfer (SETUP, ACCESS, wait for `apb_pready`) toward the bridge, and returns a per-requester response pulse with read data. It sits between the requester fabric and the bridge's APB slave port.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `APB_ADDR_WIDTH`, default 16: APB address width.
- `APB_DATA_WIDTH`, default 32: APB data width.
- Index width `IW` = ceil(log2(NUM_REQ)), minimum 1 (localparam).

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester command valid.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*APB_ADDR_WIDTH: requester i occupies `[i*AW +: AW]`.
- `req_wdata` in NUM_REQ*APB_DATA_WIDTH: requester i occupies `[i*DW +: DW]`.
- `req_ready` out NUM_REQ: one-cycle accept pulse, one-hot.
- `rsp_valid` out NUM_REQ: one-cycle completion pulse, one-hot.
- `rsp_rdata` out APB_DATA_WIDTH: read data of the last completed read. Held until the next read completes.
- `gnt_idx` out IW: index of the current or last granted requester.
- `busy` out 1: high in any state other than IDLE.
- `apb_psel`, `apb_penable`, `apb_pwrite` out 1: APB master controls.
- `apb_paddr` out APB_ADDR_WIDTH: APB address.
- `apb_pwdata` out APB_DATA_WIDTH: APB write data.
- `apb_pready` in 1: APB ready from the bridge.
- `apb_prdata` in APB_DATA_WIDTH: APB read data from the bridge.

## Operation

- Reset values:
  - All outputs are 0.
  - The priority pointer `last` is NUM_REQ-1, so requester 0 wins first.
  - The state is IDLE.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - **IDLE**:
    - If any `req_valid` is set, pick the first set bit scanning `last+1, last+2, …` with wrap modulo NUM_REQ.
    - On the clock edge:
      - Capture that requester's write/addr/wdata into `apb_pwrite`/`apb_paddr`/`apb_pwdata`.
      - Set `gnt_idx` and `last` to the winner.
      - Pulse `req_ready[winner]` for one cycle.
      - Go to SETUP.
    - With no request, stay in IDLE and leave all outputs unchanged.
  - **SETUP**: `apb_psel`=1, `apb_penable`=0, exactly one cycle, then go to ACCESS.
  - **ACCESS**:
    - `apb_psel`=1, `apb_penable`=1.
    - Address, data and write stay stable.
    - Wait for `apb_pready`=1 with no timeout.
    - On the `apb_pready` edge:
      - For reads, capture `apb_prdata` into `rsp_rdata`.
      - Go to DONE.
  - **DONE**:
    - `apb_psel`=0, `apb_penable`=0.
    - `rsp_valid[gnt_idx]`=1 for this one cycle.
    - Go to IDLE.
- APB controls are registered. They are never combinationally derived from `req_*`.
- `apb_psel` is low for at least two cycles (DONE and IDLE) between transfers. The bridge must see a fresh select after returning to its own idle.
- Requesters hold `req_valid` and payload stable until they see `req_ready`. Payload changes before that are undefined.
- `req_valid` from a requester already accepted and still asserted in IDLE is treated as a new command.
- The arbiter never splits or reorders a transfer. At most one transfer is outstanding.
- Fairness: a continuously requesting requester is granted within NUM_REQ grants.
- Write responses: `rsp_valid` pulses and `rsp_rdata` is unchanged.
- Asynchronous reset during any state:
  - Return to IDLE with all outputs at reset values.
  - The in-flight command is dropped. No `rsp_valid` is issued and the requester reissues.

## Timing

- Request seen in IDLE at edge k:
  - `req_ready` high in cycle k+1 (SETUP).
  - `apb_psel` high from cycle k+1.
  - `apb_penable` high from cycle k+2.
- `apb_pready` sampled high at edge m:
  - `rsp_valid` high in cycle m+1 (DONE).
  - `rsp_rdata` valid from cycle m+1.
  - `apb_psel` low from m+1.
- Minimum transfer occupancy is 4 cycles (IDLE, SETUP, ACCESS, DONE) when `apb_pready` is high in the first ACCESS cycle.
- Back-to-back grants are at most one every 4 cycles.
- `busy` equals (state != IDLE) and is registered.

## Test plan

- **Single write**:
  - Stimulus: requester 2 writes addr 0x1234, data 0xDEADBEEF; `apb_pready` after 3 ACCESS cycles.
  - Required response:
    - `req_ready[2]` pulse.
    - SETUP then ACCESS on APB with `pwrite`=1 and address/data stable.
    - `rsp_valid[2]` one cycle after `pready`.
    - `rsp_rdata` unchanged.
- **Single read**:
  - Stimulus: requester 0 reads addr 0x0040; slave returns 0xA5A55A5A with `pready`.
  - Required response: `rsp_valid[0]` pulse and `rsp_rdata`=0xA5A55A5A held until the next read.
- **All four request simultaneously and continuously**:
  - Required response:
    - Grant order 0,1,2,3,0,1.
    - `psel` low 2 cycles between transfers.
    - Each transfer takes exactly 4 cycles when `pready` is immediate.
- **Requesters 1 and 3 only, after a grant to 3**:
  - Required response: next grants alternate 1,3,1,3 and skip idle indices.
- **Long wait**:
  - Stimulus: `apb_pready` held low 600 cycles.
  - Required response:
    - `psel`/`penable`/`paddr`/`pwdata`/`pwrite` stable throughout.
    - No extra `req_ready`.
    - `busy`=1.
- **Reset mid-ACCESS**:
  - Stimulus: assert `rst_n`=0 asynchronously.
  - Required response:
    - All outputs 0 immediately.
    - No `rsp_valid`.
    - After release, requester 0 wins first if several request.
